// File: rtl/snes_controller_poller_if.sv
// snes_controller_poller_if: pad-side bus of the SNES poller (start/data in, latch/clock/frame out)
interface snes_controller_poller_if #(parameter int NUM_BITS = 16);
  logic                start;
  logic                data_in;
  logic                latch_out;
  logic                clk_out;
  logic [NUM_BITS-1:0] frame;
  logic                frame_valid;
  logic                busy;
  modport master (input start, data_in, output latch_out, clk_out, frame, frame_valid, busy);
  modport slave (output start, data_in, input latch_out, clk_out, frame, frame_valid, busy);
endinterface

// File: rtl/snes_controller_poller.sv
// snes_controller_poller: console-side (S)NES pad poller producing one NUM_BITS frame per start
// Ports: clk, rst (sync, active high); bus.master carries start, data_in (async pad data),
// latch_out, clk_out (idles high), frame (first bit in MSB), frame_valid (1-cycle pulse), busy.
module snes_controller_poller #(
  parameter int NUM_BITS     = 16,
  parameter int CLK_DIV      = 300,
  parameter int LATCH_CYCLES = 600
) (
  input logic                        clk,
  input logic                        rst,
  snes_controller_poller_if.master   bus
);
  localparam int CMAX = LATCH_CYCLES > CLK_DIV ? LATCH_CYCLES : CLK_DIV;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(NUM_BITS + 1);
  typedef enum logic [2:0] {IDLE, LATCH, GAP, CLK_LOW, CLK_HIGH, DONE} state_t;
  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [BW-1:0]       r_bit;
  logic [NUM_BITS-1:0] r_shift;
  logic [NUM_BITS-1:0] r_frame;
  logic [1:0]          r_sync;
  logic                r_latch;
  logic                r_clk;
  logic                r_valid;
  logic                r_busy;
  logic                w_lat_end;
  logic                w_div_end;
  logic                w_last_bit;
  assign w_lat_end  = r_cnt == CW'(LATCH_CYCLES - 1);
  assign w_div_end  = r_cnt == CW'(CLK_DIV - 1);
  assign w_last_bit = r_bit == BW'(NUM_BITS - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '1;
      r_frame <= '1;
      r_sync  <= 2'b11;
      r_latch <= 1'b0;
      r_clk   <= 1'b1;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], bus.data_in};
      r_valid <= 1'b0;
      r_cnt   <= r_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (bus.start) begin
            r_state <= LATCH;
            r_latch <= 1'b1;
            r_busy  <= 1'b1;
            r_bit   <= '0;
          end
        end
        LATCH: if (w_lat_end) begin
          r_state <= GAP;
          r_latch <= 1'b0;
          r_cnt   <= '0;
        end
        GAP: if (w_div_end) begin
          r_state <= CLK_LOW;
          r_clk   <= 1'b0;
          r_cnt   <= '0;
        end
        // sample on the last low cycle, just before the pad sees the rising edge
        CLK_LOW: if (w_div_end) begin
          r_state <= CLK_HIGH;
          r_clk   <= 1'b1;
          r_cnt   <= '0;
          r_shift <= {r_shift[NUM_BITS-2:0], r_sync[1]};
        end
        CLK_HIGH: if (w_div_end) begin
          r_cnt <= '0;
          r_bit <= r_bit + 1'b1;
          if (w_last_bit) begin
            r_state <= DONE;
            r_frame <= r_shift;
            r_valid <= 1'b1;
          end else begin
            r_state <= CLK_LOW;
            r_clk   <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.latch_out   = r_latch;
  assign bus.clk_out     = r_clk;
  assign bus.frame       = r_frame;
  assign bus.frame_valid = r_valid;
  assign bus.busy        = r_busy;
endmodule
